regfile_wb_arbiter: RTL and testbench

Shares the register file's single write port between two writeback requesters: port A (ALU/execute) and port B (load/memory unit). Arbitrates round-robin, holds the granted write in a one-entry output stage and drives the register file's write-enable, address and data inputs. Also flags decode-stage RAW hazards against the write held in the output stage. Sits between the execute/memory stages and the register file.

---
 rtl/regfile_wb_arbiter.sv | 83 ++++++++
 tb/tb_regfile_wb_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between execute (A) and memory (B)
// writeback, with a one-entry output stage and decode RAW hazard flags against the pending write.
module regfile_wb_arbiter #(
    parameter int width     = 32,
    parameter int addrWidth = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 aValid,
    input  logic [addrWidth-1:0] aAddr,
    input  logic [width-1:0]     aData,
    output logic                 aReady,
    input  logic                 bValid,
    input  logic [addrWidth-1:0] bAddr,
    input  logic [width-1:0]     bData,
    output logic                 bReady,
    input  logic                 portBusy,
    output logic                 regWriteEnable,
    output logic [addrWidth-1:0] addrD,
    output logic [width-1:0]     dataD,
    input  logic [addrWidth-1:0] qAddrA,
    input  logic [addrWidth-1:0] qAddrB,
    output logic                 hazardA,
    output logic                 hazardB
);

    logic                 out_valid;
    logic [addrWidth-1:0] out_addr;
    logic [width-1:0]     out_data;
    logic                 last_grant;

    logic                 drain;
    logic                 can_accept;
    logic                 grant_a;
    logic                 grant_b;
    logic                 accept;
    logic [addrWidth-1:0] sel_addr;
    logic [width-1:0]     sel_data;

    assign drain      = out_valid & ~portBusy;
    assign can_accept = ~out_valid | drain;

    // On contention the requester that did not win last time gets the port.
    assign grant_a  = ~reset & can_accept & aValid & (~bValid | last_grant);
    assign grant_b  = ~reset & can_accept & bValid & (~aValid | ~last_grant);
    assign accept   = grant_a | grant_b;
    assign sel_addr = grant_a ? aAddr : bAddr;
    assign sel_data = grant_a ? aData : bData;

    assign aReady         = grant_a;
    assign bReady         = grant_b;
    assign regWriteEnable = drain;
    assign addrD          = out_addr;
    assign dataD          = out_data;

    // Held through the write cycle: the register file only updates at the end of it.
    assign hazardA = out_valid & (qAddrA == out_addr) & (qAddrA != '0);
    assign hazardB = out_valid & (qAddrB == out_addr) & (qAddrB != '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_addr   <= '0;
            out_data   <= '0;
            last_grant <= 1'b1;
        end else begin
            if (accept) begin
                last_grant <= grant_b;
                if (sel_addr != '0) begin
                    out_valid <= 1'b1;
                    out_addr  <= sel_addr;
                    out_data  <= sel_data;
                end else if (drain) begin
                    // x0 writes complete the handshake but never reach the register file.
                    out_valid <= 1'b0;
                end
            end else if (drain) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: cycle table plus hand sequences, writes checked through a queue.
module tb_regfile_wb_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        aValid, bValid, portBusy;
    logic [4:0]  aAddr, bAddr, qAddrA, qAddrB;
    logic [31:0] aData, bData;
    logic        aReady, bReady, regWriteEnable, hazardA, hazardB;
    logic [4:0]  addrD;
    logic [31:0] dataD;

    regfile_wb_arbiter #(.width(32), .addrWidth(5)) dut (
        .clock(clock), .reset(reset),
        .aValid(aValid), .aAddr(aAddr), .aData(aData), .aReady(aReady),
        .bValid(bValid), .bAddr(bAddr), .bData(bData), .bReady(bReady),
        .portBusy(portBusy),
        .regWriteEnable(regWriteEnable), .addrD(addrD), .dataD(dataD),
        .qAddrA(qAddrA), .qAddrB(qAddrB), .hazardA(hazardA), .hazardB(hazardB)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        av; logic [4:0] aa; logic [31:0] ad;
        logic        bv; logic [4:0] ba; logic [31:0] bd;
        logic        busy; logic [4:0] qa; logic [4:0] qb;
        logic        ea; logic eb; logic ewe; logic [4:0] eaddr; logic eha; logic ehb;
    } vec_t;

    typedef struct { logic [4:0] addr; logic [31:0] data; } wr_t;

    vec_t tbl[$];
    wr_t  sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_wr(input logic [4:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        sb.push_back(w);
    endtask

    // Wait for the falling edge and retire any register-file write against the queue.
    task automatic sample();
        wr_t w;
        @(negedge clock);
        if (regWriteEnable) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0d data %0h expected none", addrD, dataD);
            end else begin
                w = sb.pop_front();
                chk("write_addr", 32'(addrD), 32'(w.addr));
                chk("write_data", dataD, w.data);
            end
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                         input logic busy, input logic [4:0] qa, input logic [4:0] qb);
        aValid = av; aAddr = aa; aData = ad;
        bValid = bv; bAddr = ba; bData = bd;
        portBusy = busy; qAddrA = qa; qAddrB = qb;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
        sb.delete();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        next_cycle();
    endtask

    initial begin
        vec_t v;
        logic [4:0]  a_nx, b_nx;
        logic [31:0] ad_nx, bd_nx;

        // Reset state with both requesters asserting
        reset = 1'b1;
        drive(1'b1, 5'd3, 32'h1, 1'b1, 5'd4, 32'h2, 1'b0, 5'd0, 5'd0);
        #12;
        chk("rst_aReady", 32'(aReady), 32'd0);
        chk("rst_bReady", 32'(bReady), 32'd0);
        chk("rst_we", 32'(regWriteEnable), 32'd0);
        chk("rst_addrD", 32'(addrD), 32'd0);
        chk("rst_dataD", dataD, 32'd0);
        chk("rst_hazA", 32'(hazardA), 32'd0);
        chk("rst_hazB", 32'(hazardB), 32'd0);
        do_reset();

        //              av    aa     ad            bv    ba     bd          busy  qa     qb     ea    eb    ewe   eaddr  eha   ehb
        tbl.push_back('{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0});
        tbl.push_back('{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  1'b0, 5'd5,  5'd0,  1'b0, 1'b0, 1'b1, 5'd5,  1'b1, 1'b0});
        tbl.push_back('{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  1'b0, 5'd5,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0});
        tbl.push_back('{1'b1, 5'd3,  32'h11,       1'b1, 5'd4,  32'h22, 1'b0, 5'd0,  5'd0,  1'b0, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0});
        tbl.push_back('{1'b1, 5'd3,  32'h11,       1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  5'd0,  1'b1, 1'b0, 1'b1, 5'd4,  1'b0, 1'b0});
        tbl.push_back('{1'b1, 5'd10, 32'hA0,       1'b1, 5'd11, 32'hB0, 1'b0, 5'd0,  5'd0,  1'b0, 1'b1, 1'b1, 5'd3,  1'b0, 1'b0});
        tbl.push_back('{1'b1, 5'd10, 32'hA0,       1'b1, 5'd12, 32'hC0, 1'b0, 5'd0,  5'd0,  1'b1, 1'b0, 1'b1, 5'd11, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 5'd0,  32'h0,        1'b1, 5'd12, 32'hC0, 1'b0, 5'd0,  5'd0,  1'b0, 1'b1, 1'b1, 5'd10, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  1'b1, 5'd12, 5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0});
        tbl.push_back('{1'b1, 5'd13, 32'h13,       1'b0, 5'd0,  32'h0,  1'b1, 5'd12, 5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0});
        tbl.push_back('{1'b1, 5'd13, 32'h13,       1'b0, 5'd0,  32'h0,  1'b0, 5'd12, 5'd0,  1'b1, 1'b0, 1'b1, 5'd12, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  1'b0, 5'd12, 5'd13, 1'b0, 1'b0, 1'b1, 5'd13, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 5'd0,  32'hFFFF,     1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0});
        tbl.push_back('{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  32'h99, 1'b0, 5'd0,  5'd0,  1'b0, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0});
        tbl.push_back('{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 5'd9,  1'b0, 1'b0});
        tbl.push_back('{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  1'b0, 5'd9,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0});
        tbl.push_back('{1'b1, 5'd14, 32'h14,       1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0});
        tbl.push_back('{1'b1, 5'd0,  32'hFFFF,     1'b0, 5'd0,  32'h0,  1'b0, 5'd14, 5'd0,  1'b1, 1'b0, 1'b1, 5'd14, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  1'b0, 5'd14, 5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0});

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            drive(v.av, v.aa, v.ad, v.bv, v.ba, v.bd, v.busy, v.qa, v.qb);
            if (v.ea && v.aa != 5'd0) push_wr(v.aa, v.ad);
            if (v.eb && v.ba != 5'd0) push_wr(v.ba, v.bd);
            sample();
            chk($sformatf("tbl%0d_aReady", i), 32'(aReady), 32'(v.ea));
            chk($sformatf("tbl%0d_bReady", i), 32'(bReady), 32'(v.eb));
            chk($sformatf("tbl%0d_we", i), 32'(regWriteEnable), 32'(v.ewe));
            if (v.ewe) chk($sformatf("tbl%0d_addrD", i), 32'(addrD), 32'(v.eaddr));
            chk($sformatf("tbl%0d_hazA", i), 32'(hazardA), 32'(v.eha));
            chk($sformatf("tbl%0d_hazB", i), 32'(hazardB), 32'(v.ehb));
            next_cycle();
        end
        chk("tbl_sb_empty", 32'(sb.size()), 32'd0);

        // Both requesters valid from reset: A first, then strict alternation
        do_reset();
        a_nx = 5'd3; ad_nx = 32'h11; b_nx = 5'd4; bd_nx = 32'h22;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, a_nx, ad_nx, 1'b1, b_nx, bd_nx, 1'b0, 5'd0, 5'd0);
            sample();
            chk($sformatf("rr%0d_aReady", i), 32'(aReady), 32'((i % 2) == 0));
            chk($sformatf("rr%0d_bReady", i), 32'(bReady), 32'((i % 2) == 1));
            if ((i % 2) == 0) begin
                push_wr(a_nx, ad_nx);
                a_nx = a_nx + 5'd2; ad_nx = ad_nx + 32'h100;
            end else begin
                push_wr(b_nx, bd_nx);
                b_nx = b_nx + 5'd2; bd_nx = bd_nx + 32'h100;
            end
            next_cycle();
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
        sample();
        next_cycle();
        chk("rr_sb_empty", 32'(sb.size()), 32'd0);

        // Port busy stalls the stage and the waiting requester
        drive(1'b1, 5'd7, 32'h55, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
        sample();
        chk("busy_acc7", 32'(aReady), 32'd1);
        push_wr(5'd7, 32'h55);
        next_cycle();
        drive(1'b1, 5'd8, 32'h88, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0);
        for (int i = 0; i < 3; i++) begin
            sample();
            chk($sformatf("busy%0d_we", i), 32'(regWriteEnable), 32'd0);
            chk($sformatf("busy%0d_aReady", i), 32'(aReady), 32'd0);
            next_cycle();
        end
        portBusy = 1'b0;
        sample();
        chk("busy_release_we", 32'(regWriteEnable), 32'd1);
        chk("busy_release_aReady", 32'(aReady), 32'd1);
        push_wr(5'd8, 32'h88);
        next_cycle();
        aValid = 1'b0;
        sample();
        chk("busy_w8_we", 32'(regWriteEnable), 32'd1);
        next_cycle();
        chk("busy_sb_empty", 32'(sb.size()), 32'd0);

        // Reset while a write to r6 is stalled: it must never be written
        drive(1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'd0, 1'b0, 5'd6, 5'd0);
        sample();
        chk("mid_acc6", 32'(aReady), 32'd1);
        push_wr(5'd6, 32'h66);
        next_cycle();
        aValid = 1'b0; portBusy = 1'b1;
        sample();
        chk("mid_held_we", 32'(regWriteEnable), 32'd0);
        chk("mid_held_haz", 32'(hazardA), 32'd1);
        #1;
        reset = 1'b1;
        aValid = 1'b1; aAddr = 5'd15; aData = 32'h15;
        sb.delete();
        #1;
        chk("mid_rst_we", 32'(regWriteEnable), 32'd0);
        chk("mid_rst_aReady", 32'(aReady), 32'd0);
        chk("mid_rst_haz", 32'(hazardA), 32'd0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        drive(1'b1, 5'd20, 32'h20, 1'b1, 5'd21, 32'h21, 1'b0, 5'd0, 5'd0);
        #1;
        chk("post_rst_aReady", 32'(aReady), 32'd1);
        chk("post_rst_bReady", 32'(bReady), 32'd0);
        push_wr(5'd20, 32'h20);
        next_cycle();
        aValid = 1'b0;
        sample();
        chk("post_rst_bReady2", 32'(bReady), 32'd1);
        push_wr(5'd21, 32'h21);
        next_cycle();
        bValid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            next_cycle();
        end
        chk("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
